// File: rtl/song_reader_ctrl_if.sv
// Song ROM fetch bus plus note-player handshake between the song
// reader sequencer (master) and the ROM / note player side (slave).
interface song_reader_ctrl_if #(
    parameter int SONG_W = 2,
    parameter int ADDR_W = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic [SONG_W+ADDR_W-1:0] rom_addr;
    logic [NOTE_W+DUR_W-1:0]  rom_data;
    logic                     note_done;
    logic                     new_note;
    logic [NOTE_W-1:0]        note;
    logic [DUR_W-1:0]         duration;

    modport master (
        output rom_addr,
        output new_note,
        output note,
        output duration,
        input  rom_data,
        input  note_done
    );

    modport slave (
        input  rom_addr,
        input  new_note,
        input  note,
        input  duration,
        output rom_data,
        output note_done
    );
endinterface

// File: rtl/song_reader_ctrl.sv
// Song reader sequencer: walks note addresses of the selected song,
// fetches each ROM word and hands it to the note player.
module song_reader_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int SONG_W  = 2,
    parameter int NOTE_W  = 6,
    parameter int DUR_W   = 6,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              next_song,
    song_reader_ctrl_if.master bus,
    output logic [SONG_W-1:0] song,
    output logic              playing,
    output logic              song_done
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SONG_W-1:0]  song_q, song_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               new_note_q, new_note_d;
    logic               song_done_q, song_done_d;
    logic               playing_q, playing_d;

    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;

    assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = bus.rom_data[DUR_W-1:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        song_d      = song_q;
        note_d      = note_q;
        dur_d       = dur_q;
        cnt_d       = cnt_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        // Skipping songs abandons whatever fetch or note is in flight.
        if (next_song) begin
            song_d  = song_q + 1'b1;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = play ? S_FETCH : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (play) begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                end
                S_FETCH: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    note_d = rom_note;
                    dur_d  = rom_dur;
                    if (rom_dur != '0) begin
                        new_note_d = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        song_done_d = 1'b1;
                        addr_d      = '0;
                        state_d     = S_END;
                    end
                end
                S_WAIT: begin
                    if (bus.note_done) begin
                        if (&addr_q) begin
                            song_done_d = 1'b1;
                            addr_d      = '0;
                            state_d     = S_END;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            cnt_d   = '0;
                            state_d = play ? S_FETCH : S_IDLE;
                        end
                    end
                end
                S_END: begin
                    // Require play to drop so a finished song never auto-replays.
                    if (!play) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        playing_d = (state_d == S_FETCH) ||
                    (state_d == S_LATCH) ||
                    (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            song_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            cnt_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            song_q      <= song_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            cnt_q       <= cnt_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
            playing_q   <= playing_d;
        end
    end

    assign bus.rom_addr = {song_q, addr_q};
    assign bus.new_note = new_note_q;
    assign bus.note     = note_q;
    assign bus.duration = dur_q;
    assign song         = song_q;
    assign playing      = playing_q;
    assign song_done    = song_done_q;

endmodule

// File: tb/tb_song_reader_ctrl.sv
// Bench for song_reader_ctrl: directed scenarios plus random play,
// skip, note_done and reset traffic against a transaction-level model.
module tb_song_reader_ctrl;

    localparam int ROM_LAT = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic       next_song;
    logic [1:0] song;
    logic       playing;
    logic       song_done;

    int checks = 0;
    int errors = 0;

    song_reader_ctrl_if #(
        .SONG_W(2), .ADDR_W(5), .NOTE_W(6), .DUR_W(6)
    ) bus ();

    song_reader_ctrl #(
        .ADDR_W(5), .SONG_W(2), .NOTE_W(6), .DUR_W(6), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .next_song (next_song),
        .bus       (bus),
        .song      (song),
        .playing   (playing),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [128];
    logic [11:0] pipe [ROM_LAT];

    always @(posedge clk) begin
        pipe[0] <= mem[bus.rom_addr];
        for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rom_data = pipe[ROM_LAT-1];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 paused/idle, 1 fetching (countdown to latch edge),
    // 2 note sounding, 3 song finished awaiting play release.
    int         m_mode = 0;
    int         m_cd = 0;
    logic [1:0] m_song = '0;
    logic [4:0] m_addr = '0;
    logic [5:0] m_note = '0;
    logic [5:0] m_dur = '0;
    logic       e_new, e_done;

    always @(posedge clk) begin
        logic [11:0] w;
        #1;
        e_new  = 1'b0;
        e_done = 1'b0;
        if (!reset) begin
            m_mode = 0; m_song = '0; m_addr = '0;
            m_note = '0; m_dur = '0;
        end else if (next_song) begin
            m_song = m_song + 2'd1;
            m_addr = '0;
            m_mode = play ? 1 : 0;
            m_cd   = ROM_LAT + 1;
        end else begin
            case (m_mode)
                0: if (play) begin m_mode = 1; m_cd = ROM_LAT + 1; end
                1: begin
                    m_cd = m_cd - 1;
                    if (m_cd == 0) begin
                        w = mem[{m_song, m_addr}];
                        m_note = w[11:6];
                        m_dur  = w[5:0];
                        if (m_dur != 0) begin
                            e_new = 1'b1; m_mode = 2;
                        end else begin
                            e_done = 1'b1; m_addr = '0; m_mode = 3;
                        end
                    end
                end
                2: if (bus.note_done) begin
                    if (m_addr == 5'd31) begin
                        e_done = 1'b1; m_addr = '0; m_mode = 3;
                    end else begin
                        m_addr = m_addr + 5'd1;
                        m_mode = play ? 1 : 0;
                        m_cd   = ROM_LAT + 1;
                    end
                end
                default: if (!play) m_mode = 0;
            endcase
        end
        chk("rom_addr", 16'(bus.rom_addr), 16'({m_song, m_addr}));
        chk("song", 16'(song), 16'(m_song));
        chk("note", 16'(bus.note), 16'(m_note));
        chk("duration", 16'(bus.duration), 16'(m_dur));
        chk("new_note", 16'(bus.new_note), 16'(e_new));
        chk("song_done", 16'(song_done), 16'(e_done));
        chk("playing", 16'(playing), 16'(m_mode == 1 || m_mode == 2));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_evt(input string nm);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.new_note || song_done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for new_note/song_done", nm);
    endtask

    task automatic play_note(input string nm);
        bus.note_done = 1'b1;
        tick(1);
        bus.note_done = 1'b0;
        wait_evt(nm);
    endtask

    initial begin
        logic [5:0] n, d;
        reset = 1'b0; play = 1'b0; next_song = 1'b0;
        bus.note_done = 1'b0;
        for (int i = 0; i < 128; i++) begin
            n = 6'($urandom_range(0, 63));
            d = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            if ((i < 32 || i == 32 || i == 33 || i == 34 || i == 64 || i == 96)
                && d == 6'd0) d = 6'd1;
            mem[i] = {n, d};
        end
        mem[0]  = {6'd12, 6'd8};
        mem[35] = {6'd5, 6'd0};

        // Reset state
        tick(3);
        chk("rst_new_note", 16'(bus.new_note), 16'd0);
        chk("rst_playing", 16'(playing), 16'd0);
        chk("rst_rom_addr", 16'(bus.rom_addr), 16'd0);
        chk("rst_note", 16'(bus.note), 16'd0);
        reset = 1'b1;
        play  = 1'b1;

        // First note: latency ROM_LAT+2
        tick(2);
        chk("a_early_new", 16'(bus.new_note), 16'd0);
        chk("a_playing", 16'(playing), 16'd1);
        tick(1);
        chk("a_new_note", 16'(bus.new_note), 16'd1);
        chk("a_note", 16'(bus.note), 16'd12);
        chk("a_dur", 16'(bus.duration), 16'd8);
        chk("a_rom_addr", 16'(bus.rom_addr), 16'd0);

        // Advance to addr 5, then note_done with play held
        for (int i = 0; i < 5; i++) play_note("b_adv");
        chk("b_at5", 16'(bus.rom_addr), 16'd5);
        bus.note_done = 1'b1; tick(1); bus.note_done = 1'b0;
        chk("b_addr6", 16'(bus.rom_addr), 16'd6);
        tick(1);
        chk("b_no_new", 16'(bus.new_note), 16'd0);
        tick(1);
        chk("b_new", 16'(bus.new_note), 16'd1);

        // Pause at note boundary
        play = 1'b0;
        bus.note_done = 1'b1; tick(1); bus.note_done = 1'b0;
        chk("p_playing", 16'(playing), 16'd0);
        chk("p_addr", 16'(bus.rom_addr), 16'd7);
        tick(3);
        chk("p_no_new", 16'(bus.new_note), 16'd0);
        chk("p_hold", 16'(bus.rom_addr), 16'd7);
        play = 1'b1;
        tick(3);
        chk("p_resume", 16'(bus.new_note), 16'd1);

        // Run to address 31 and wrap to END
        for (int i = 0; i < 40 && m_addr != 5'd31; i++) play_note("c_adv");
        chk("c_at31", 16'(bus.rom_addr), 16'd31);
        bus.note_done = 1'b1; tick(1); bus.note_done = 1'b0;
        chk("c_done", 16'(song_done), 16'd1);
        chk("c_addr0", 16'(bus.rom_addr), 16'd0);
        chk("c_idle", 16'(playing), 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("c_no_replay", 16'(bus.new_note), 16'd0);
        end
        play = 1'b0; tick(2); play = 1'b1; tick(3);
        chk("c_restart", 16'(bus.new_note), 16'd1);
        chk("c_restart_note", 16'(bus.note), 16'd12);

        // Song 1 has a zero-duration marker at addr 3
        next_song = 1'b1; tick(1); next_song = 1'b0;
        chk("d_song", 16'(song), 16'd1);
        chk("d_addr", 16'(bus.rom_addr), 16'h20);
        wait_evt("d_first");
        play_note("d_adv");
        play_note("d_adv");
        bus.note_done = 1'b1; tick(1); bus.note_done = 1'b0;
        tick(2);
        chk("d_marker_done", 16'(song_done), 16'd1);
        chk("d_marker_new", 16'(bus.new_note), 16'd0);
        chk("d_marker_addr", 16'(bus.rom_addr), 16'h20);

        // next_song beats a coincident note_done, wrapping song 3 -> 0
        next_song = 1'b1; tick(1); next_song = 1'b0;
        wait_evt("e_s2");
        next_song = 1'b1; tick(1); next_song = 1'b0;
        wait_evt("e_s3");
        chk("e_song3", 16'(song), 16'd3);
        next_song = 1'b1; bus.note_done = 1'b1; tick(1);
        next_song = 1'b0; bus.note_done = 1'b0;
        chk("e_wrap", 16'(song), 16'd0);
        chk("e_addr", 16'(bus.rom_addr), 16'd0);
        chk("e_no_done", 16'(song_done), 16'd0);
        tick(2);
        chk("e_new", 16'(bus.new_note), 16'd1);
        chk("e_note", 16'(bus.note), 16'd12);

        // Reset mid-WAIT, then reset together with next_song
        reset = 1'b0; tick(1);
        chk("f_playing", 16'(playing), 16'd0);
        chk("f_note", 16'(bus.note), 16'd0);
        reset = 1'b1;
        next_song = 1'b1; tick(1); next_song = 1'b0;
        wait_evt("f_s1");
        reset = 1'b0; next_song = 1'b1; tick(1);
        chk("f2_song", 16'(song), 16'd0);
        chk("f2_playing", 16'(playing), 16'd0);
        chk("f2_dur", 16'(bus.duration), 16'd0);
        reset = 1'b1; next_song = 1'b0;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if ($urandom_range(0, 99) < 3) play = ~play;
            next_song     = ($urandom_range(0, 99) == 0);
            bus.note_done = ($urandom_range(0, 6) == 0);
            reset         = ($urandom_range(0, 299) != 0);
        end
        tick(1);
        reset = 1'b1; next_song = 1'b0; bus.note_done = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_reader_ctrl.md
Name: song_reader_ctrl

Overview:
- Sequencer for the song reader datapath: owns the 5-bit note address and the 2-bit song select, and fetches each note/duration word from the song ROM.
- Hands each note to the note player with a one-cycle new_note strobe, then waits for note_done before advancing.
- Handles play/pause at note boundaries, skip to next song, and end-of-song detection (address wrap or zero-duration marker).
- Sits between the top-level user controls and the song ROM / note player.

Parameters:
- ADDR_W, 5, note address width within a song (32 notes per song)
- SONG_W, 2, song select width (4 songs)
- NOTE_W, 6, note field width in the ROM word
- DUR_W, 6, duration field width in the ROM word
- ROM_LAT, 1, ROM read latency in cycles (1..3)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- play  in  1  level; 1 = play, 0 = pause
- next_song  in  1  one-cycle pulse; skip to the next song
- rom_addr  out  SONG_W+ADDR_W  {song, addr}, driven continuously
- rom_data  in  NOTE_W+DUR_W  {note, duration}, valid ROM_LAT cycles after rom_addr is stable
- note_done  in  1  one-cycle pulse from the note player
- new_note  out  1  one-cycle pulse; note/duration are valid from this cycle onward
- note  out  NOTE_W  latched note
- duration  out  DUR_W  latched duration
- song  out  SONG_W  current song index
- playing  out  1  high in FETCH, LATCH and WAIT
- song_done  out  1  one-cycle pulse at end of song

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; addr=0; song=0; note=0; duration=0.
  - new_note=0, song_done=0, playing=0.
  - Reset wins over every other input.
- States: IDLE, FETCH, LATCH, WAIT, END.
- IDLE:
  - play==1 -> FETCH.
  - Otherwise hold.
- FETCH:
  - Hold rom_addr stable and count ROM_LAT cycles.
  - Then -> LATCH.
  - rom_addr must not change while in FETCH.
- LATCH (one cycle):
  - Capture note and duration from rom_data.
  - duration!=0: pulse new_note -> WAIT.
  - duration==0 (end marker): no new_note; pulse song_done; addr<=0 -> END.
- WAIT:
  - Hold note/duration.
  - On note_done:
    - addr==all-ones: pulse song_done; addr<=0 -> END.
    - Else addr<=addr+1; -> FETCH if play==1, otherwise -> IDLE (pause at the note boundary).
  - play deassertion alone does not abort a sounding note.
- END:
  - Wait for play==0, then -> IDLE. This blocks auto-replay of the same song.
- next_song (any state except reset):
  - song<=song+1, wrapping 3->0; addr<=0; note and duration hold.
  - play==1: -> FETCH, else -> IDLE.
  - Any in-flight fetch or WAIT is abandoned.
  - A note_done in the same cycle is ignored; no song_done is generated.
  - Priority: reset > next_song > note_done.
- Timing:
  - note_done outside WAIT is ignored.
  - new_note and song_done are registered and never both high in the same cycle.
  - Latency from play rising in IDLE to new_note is ROM_LAT+2 cycles (IDLE->FETCH 1, FETCH ROM_LAT, LATCH 1; new_note is registered).
  - note_done to the next new_note is ROM_LAT+2 cycles.
- Width rules:
  - addr wraps only via the end-of-song path; it never silently overflows.
  - song wraps modulo 2^SONG_W.
  - rom_addr = {song, addr}.

Test Plan:
- Reset, then play=1 with ROM song0 addr0 = {note 6'd12, dur 6'd8} -> rom_addr=7'd0; new_note pulses 3 cycles after play (ROM_LAT=1); note=12, duration=8; playing=1.
- note_done in WAIT at addr 5 with play=1 -> rom_addr becomes {0,6} next cycle; new_note 3 cycles later. Repeat with play=0 -> state IDLE, playing=0, addr=6 held; play=1 resumes at addr 6.
- Run song0 to addr 31, pulse note_done -> song_done one cycle, addr=0, END. With play held 1, no new_note. play=0 then play=1 -> restarts at rom_addr 0.
- ROM word at song1 addr 3 has duration=0 -> no new_note; song_done pulses; addr=0; END.
- next_song together with note_done while in WAIT, song=3, play=1 -> song=0, addr=0, FETCH; no song_done; next new_note carries the song0 addr0 data.
- reset=0 asserted mid-WAIT, and again simultaneous with next_song -> all outputs 0 next cycle; song=0; IDLE.
